// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-triggered, fixed-priority interrupt controller.
// Latches rising edges of irq into a pending register, applies a software
// mask, picks the lowest-index eligible source and hands one request plus a
// handler vector to the control unit. One interrupt in service at a time.
// Optional build macro IRQ_SYNC_EN: when defined, each irq bit is passed
// through a 2-flop synchronizer before edge detection (adds 2 cycles latency).
module interrupt_controller #(
  parameter int          NUM_IRQ      = 2,
  parameter logic [31:0] VECTOR_BASE  = 32'h0000_0100,
  parameter int          VECTOR_SHIFT = 3,
  parameter int          ID_W         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               MaskWr,
  input  logic [NUM_IRQ-1:0] MaskData,
  input  logic               IntAck,
  input  logic               EOI,
  output logic               IntReq,
  output logic [ID_W-1:0]    IntId,
  output logic [31:0]        Vector,
  output logic               InService,
  output logic [NUM_IRQ-1:0] Pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [NUM_IRQ-1:0] pending_reg, pending_next;
  logic [NUM_IRQ-1:0] mask_reg;
  logic [NUM_IRQ-1:0] irq_d_reg;
  logic [NUM_IRQ-1:0] irq_in;
  logic [NUM_IRQ-1:0] irq_edge;
  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [ID_W-1:0]    id_reg, id_next;
  logic [ID_W-1:0]    winner;
  logic               any_elig;
  logic               take_ack;
  logic               withdraw;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_reg, sync2_reg;

  // Two-flop synchronizer for asynchronous request lines
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= irq;
      sync2_reg <= sync1_reg;
    end
  end

  assign irq_in = sync2_reg;
`else
  assign irq_in = irq;
`endif

  // Per-source rising-edge detect against the delayed copy of the request
  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_edge
      assign irq_edge[gi] = irq_in[gi] & ~irq_d_reg[gi];
      assign elig[gi]     = pending_reg[gi] & mask_reg[gi];
      assign ack_clr[gi]  = take_ack && (id_reg == ID_W'(gi));
    end
  endgenerate

  assign any_elig = |elig;

  // Fixed priority: lowest index among eligible sources wins
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) winner = ID_W'(i);
    end
  end

  // Handshake qualifiers only meaningful while a request is outstanding
  assign take_ack = (state_reg == REQ) && IntAck;
  assign withdraw = (state_reg == REQ) && !IntAck &&
                    (!mask_reg[id_reg] || !pending_reg[id_reg]);

  // FSM state register
  always_ff @(posedge Clock) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM next-state logic; ack beats withdrawal in the same cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_elig) state_next = REQ;
      REQ: begin
        if (take_ack)      state_next = SERVICE;
        else if (withdraw) state_next = IDLE;
      end
      SERVICE: if (EOI) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state only
  always_comb begin
    IntReq    = 1'b0;
    InService = 1'b0;
    case (state_reg)
      REQ:     IntReq    = 1'b1;
      SERVICE: InService = 1'b1;
      default: ;
    endcase
  end

  // Pending update: a new edge on the acked source wins over the ack clear
  always_comb begin
    pending_next = (pending_reg & ~ack_clr) | irq_edge;
  end

  // Source ID is captured only when leaving IDLE, then frozen through SERVICE
  always_comb begin
    id_next = id_reg;
    if (state_reg == IDLE && any_elig) id_next = winner;
  end

  // Datapath registers: edge history, pending, mask and latched source ID
  always_ff @(posedge Clock) begin
    if (Reset) begin
      irq_d_reg   <= '0;
      pending_reg <= '0;
      mask_reg    <= '0;
      id_reg      <= '0;
    end else begin
      irq_d_reg   <= irq_in;
      pending_reg <= pending_next;
      id_reg      <= id_next;
      if (MaskWr) mask_reg <= MaskData;
    end
  end

  assign IntId   = id_reg;
  assign Pending = pending_reg;
  assign Vector  = VECTOR_BASE + (32'(id_reg) << VECTOR_SHIFT);

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed-vector bench for interrupt_controller (default build, irq used
// directly). Inputs change 1 time unit after the rising edge; outputs are
// checked at that same point, well away from the next active edge.
module tb_interrupt_controller;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [1:0]  irq;
  logic        MaskWr;
  logic [1:0]  MaskData;
  logic        IntAck;
  logic        EOI;
  logic        IntReq;
  logic [0:0]  IntId;
  logic [31:0] Vector;
  logic        InService;
  logic [1:0]  Pending;

  int vectors     = 0;
  int miscompares = 0;

  interrupt_controller dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .irq       (irq),
    .MaskWr    (MaskWr),
    .MaskData  (MaskData),
    .IntAck    (IntAck),
    .EOI       (EOI),
    .IntReq    (IntReq),
    .IntId     (IntId),
    .Vector    (Vector),
    .InService (InService),
    .Pending   (Pending)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; irq = 2'b00; MaskWr = 1'b0; MaskData = 2'b00; IntAck = 1'b0; EOI = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    vectors++; if (IntReq !== 1'b0) begin miscompares++; $display("FAIL reset_intreq got=%0b exp=0", IntReq); end
    vectors++; if (IntId !== 1'b0) begin miscompares++; $display("FAIL reset_intid got=%0d exp=0", IntId); end
    vectors++; if (Vector !== 32'h100) begin miscompares++; $display("FAIL reset_vector got=%h exp=00000100", Vector); end
    vectors++; if (InService !== 1'b0) begin miscompares++; $display("FAIL reset_inservice got=%0b exp=0", InService); end
    vectors++; if (Pending !== 2'b00) begin miscompares++; $display("FAIL reset_pending got=%b exp=00", Pending); end
    $display("txn reset done");
  endtask

  task automatic test_basic();
    MaskWr = 1'b1; MaskData = 2'b11; tick(); MaskWr = 1'b0;
    irq = 2'b10; tick();
    vectors++; if (Pending !== 2'b10) begin miscompares++; $display("FAIL basic_pending got=%b exp=10", Pending); end
    vectors++; if (IntReq !== 1'b0) begin miscompares++; $display("FAIL basic_req_early got=%0b exp=0", IntReq); end
    tick();
    vectors++; if (IntReq !== 1'b1) begin miscompares++; $display("FAIL basic_req got=%0b exp=1", IntReq); end
    vectors++; if (IntId !== 1'b1) begin miscompares++; $display("FAIL basic_id got=%0d exp=1", IntId); end
    vectors++; if (Vector !== 32'h108) begin miscompares++; $display("FAIL basic_vector got=%h exp=00000108", Vector); end
    irq = 2'b00; IntAck = 1'b1; tick(); IntAck = 1'b0;
    vectors++; if (IntReq !== 1'b0) begin miscompares++; $display("FAIL basic_ack_req got=%0b exp=0", IntReq); end
    vectors++; if (InService !== 1'b1) begin miscompares++; $display("FAIL basic_ack_insvc got=%0b exp=1", InService); end
    vectors++; if (Pending !== 2'b00) begin miscompares++; $display("FAIL basic_ack_pending got=%b exp=00", Pending); end
    EOI = 1'b1; tick(); EOI = 1'b0;
    vectors++; if (InService !== 1'b0) begin miscompares++; $display("FAIL basic_eoi got=%0b exp=0", InService); end
    tick();
    vectors++; if (IntReq !== 1'b0) begin miscompares++; $display("FAIL basic_idle_req got=%0b exp=0", IntReq); end
    $display("txn basic service done");
  endtask

  task automatic test_priority();
    irq = 2'b10; tick(); tick();
    irq = 2'b11; tick();
    vectors++; if (Pending !== 2'b11) begin miscompares++; $display("FAIL prio_pending got=%b exp=11", Pending); end
    vectors++; if (IntId !== 1'b1) begin miscompares++; $display("FAIL prio_frozen_id got=%0d exp=1", IntId); end
    vectors++; if (IntReq !== 1'b1) begin miscompares++; $display("FAIL prio_frozen_req got=%0b exp=1", IntReq); end
    IntAck = 1'b1; tick(); IntAck = 1'b0;
    vectors++; if (Pending !== 2'b01) begin miscompares++; $display("FAIL prio_ack_pending got=%b exp=01", Pending); end
    vectors++; if (IntId !== 1'b1) begin miscompares++; $display("FAIL prio_svc_id got=%0d exp=1", IntId); end
    EOI = 1'b1; tick(); EOI = 1'b0;
    vectors++; if (IntReq !== 1'b0) begin miscompares++; $display("FAIL prio_eoi_req got=%0b exp=0", IntReq); end
    tick();
    vectors++; if (IntReq !== 1'b1) begin miscompares++; $display("FAIL prio_rereq got=%0b exp=1", IntReq); end
    vectors++; if (IntId !== 1'b0) begin miscompares++; $display("FAIL prio_rereq_id got=%0d exp=0", IntId); end
    vectors++; if (Vector !== 32'h100) begin miscompares++; $display("FAIL prio_vector got=%h exp=00000100", Vector); end
    IntAck = 1'b1; tick(); IntAck = 1'b0;
    EOI = 1'b1; tick(); EOI = 1'b0;
    irq = 2'b00; tick();
    $display("txn priority/freeze done");
  endtask

  task automatic test_mask();
    MaskWr = 1'b1; MaskData = 2'b01; tick(); MaskWr = 1'b0;
    irq = 2'b10; tick(); tick();
    vectors++; if (Pending !== 2'b10) begin miscompares++; $display("FAIL mask_pending got=%b exp=10", Pending); end
    vectors++; if (IntReq !== 1'b0) begin miscompares++; $display("FAIL mask_blocked got=%0b exp=0", IntReq); end
    MaskWr = 1'b1; MaskData = 2'b11; tick(); MaskWr = 1'b0;
    vectors++; if (IntReq !== 1'b0) begin miscompares++; $display("FAIL mask_wr_latency got=%0b exp=0", IntReq); end
    tick();
    vectors++; if (IntReq !== 1'b1) begin miscompares++; $display("FAIL mask_unmask_req got=%0b exp=1", IntReq); end
    vectors++; if (IntId !== 1'b1) begin miscompares++; $display("FAIL mask_unmask_id got=%0d exp=1", IntId); end
    IntAck = 1'b1; tick(); IntAck = 1'b0;
    EOI = 1'b1; tick(); EOI = 1'b0;
    irq = 2'b00; tick();
    $display("txn masked source done");
  endtask

  task automatic test_withdraw();
    irq = 2'b01; tick(); tick();
    vectors++; if (IntReq !== 1'b1 || IntId !== 1'b0) begin miscompares++; $display("FAIL wd_req got=%0b/%0d exp=1/0", IntReq, IntId); end
    MaskWr = 1'b1; MaskData = 2'b00; tick(); MaskWr = 1'b0;
    vectors++; if (IntReq !== 1'b1) begin miscompares++; $display("FAIL wd_still_req got=%0b exp=1", IntReq); end
    tick();
    vectors++; if (IntReq !== 1'b0) begin miscompares++; $display("FAIL wd_withdrawn got=%0b exp=0", IntReq); end
    vectors++; if (Pending !== 2'b01) begin miscompares++; $display("FAIL wd_pending got=%b exp=01", Pending); end
    MaskWr = 1'b1; MaskData = 2'b11; tick(); MaskWr = 1'b0;
    tick();
    vectors++; if (IntReq !== 1'b1) begin miscompares++; $display("FAIL wd_rearb got=%0b exp=1", IntReq); end
    IntAck = 1'b1; tick(); IntAck = 1'b0;
    EOI = 1'b1; tick(); EOI = 1'b0;
    irq = 2'b00; tick();
    $display("txn withdraw done");
  endtask

  task automatic test_back_to_back();
    irq = 2'b01; tick();
    irq = 2'b00; tick();
    // rising edge on source 0 lands in the very cycle it is acked
    irq = 2'b01; IntAck = 1'b1; tick(); IntAck = 1'b0;
    vectors++; if (InService !== 1'b1) begin miscompares++; $display("FAIL coll_insvc got=%0b exp=1", InService); end
    vectors++; if (Pending !== 2'b01) begin miscompares++; $display("FAIL coll_pending got=%b exp=01", Pending); end
    IntAck = 1'b1; tick(); IntAck = 1'b0;
    vectors++; if (InService !== 1'b1 || Pending !== 2'b01) begin miscompares++; $display("FAIL stray_ack_svc got=%0b/%b exp=1/01", InService, Pending); end
    EOI = 1'b1; tick(); EOI = 1'b0;
    tick();
    vectors++; if (IntReq !== 1'b1 || IntId !== 1'b0) begin miscompares++; $display("FAIL coll_rereq got=%0b/%0d exp=1/0", IntReq, IntId); end
    EOI = 1'b1; tick(); EOI = 1'b0;
    vectors++; if (IntReq !== 1'b1 || InService !== 1'b0) begin miscompares++; $display("FAIL stray_eoi got=%0b/%0b exp=1/0", IntReq, InService); end
    IntAck = 1'b1; tick(); IntAck = 1'b0;
    EOI = 1'b1; tick(); EOI = 1'b0;
    vectors++; if (Pending !== 2'b00) begin miscompares++; $display("FAIL coll_drained got=%b exp=00", Pending); end
    irq = 2'b00; IntAck = 1'b1; tick(); IntAck = 1'b0;
    vectors++; if (IntReq !== 1'b0 || InService !== 1'b0) begin miscompares++; $display("FAIL stray_ack_idle got=%0b/%0b exp=0/0", IntReq, InService); end
    $display("txn collision and stray handshakes done");
  endtask

  task automatic test_reset_service();
    irq = 2'b11; tick(); tick();
    IntAck = 1'b1; tick(); IntAck = 1'b0;
    vectors++; if (InService !== 1'b1 || Pending !== 2'b10) begin miscompares++; $display("FAIL rs_setup got=%0b/%b exp=1/10", InService, Pending); end
    irq = 2'b00; Reset = 1'b1; tick(); Reset = 1'b0;
    vectors++; if (InService !== 1'b0 || IntReq !== 1'b0) begin miscompares++; $display("FAIL rs_outputs got=%0b/%0b exp=0/0", InService, IntReq); end
    vectors++; if (Pending !== 2'b00) begin miscompares++; $display("FAIL rs_pending got=%b exp=00", Pending); end
    vectors++; if (IntId !== 1'b0 || Vector !== 32'h100) begin miscompares++; $display("FAIL rs_id got=%0d/%h exp=0/00000100", IntId, Vector); end
    // mask must have cleared: a fresh edge stays pending but is never requested
    irq = 2'b10; tick(); tick(); tick();
    vectors++; if (Pending !== 2'b10 || IntReq !== 1'b0) begin miscompares++; $display("FAIL rs_mask_cleared got=%b/%0b exp=10/0", Pending, IntReq); end
    irq = 2'b00; tick();
    $display("txn reset in service done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_withdraw();
    test_back_to_back();
    test_reset_service();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Edge-triggered, fixed-priority interrupt controller in front of the control unit's interrupt input.
- Latches device requests and applies a software-written mask.
- Selects the highest-priority pending source and presents one request plus a 32-bit handler vector to the control unit.
- Tracks the single in-service interrupt until the handler signals end-of-interrupt (EOI). No nesting.

Parameters:
NUM_IRQ, 2, number of interrupt sources (1..16); source 0 has highest priority
VECTOR_BASE, 32'h0000_0100, handler address for source 0
VECTOR_SHIFT, 3, log2 of the byte spacing between consecutive handler vectors
ID_W, (NUM_IRQ>1 ? $clog2(NUM_IRQ) : 1), width of the source ID (derived; not overridden)

Ports:
Clock     in   1        system clock; all state updates on rising edge
Reset     in   1        synchronous, active-high
irq       in   NUM_IRQ  device request lines; rising edge = request
MaskWr    in   1        load MaskData into mask register
MaskData  in   NUM_IRQ  1 = source enabled
IntAck    in   1        1-cycle pulse from control unit at an instruction boundary, accepting the current request
EOI       in   1        1-cycle pulse, handler finished
IntReq    out  1        request to control unit
IntId     out  ID_W     ID of the requested or in-service source
Vector    out  32       VECTOR_BASE + (IntId << VECTOR_SHIFT)
InService out  1        a handler is active
Pending   out  NUM_IRQ  pending register, for status read

Behaviour:
- Reset: on a Clock edge with Reset=1, all internal state clears.
  - state=IDLE; pending=0; mask=0; irq_d=0.
  - Outputs: IntReq=0, IntId=0, Vector=VECTOR_BASE, InService=0.
  - Reset overrides every other input in that cycle, including mid-REQ or mid-SERVICE.
- Edge detect:
  - irq_d is a register of irq.
  - edge[i] = irq[i] & ~irq_d[i].
  - pending[i] sets on the clock after the edge.
  - A level held high produces exactly one request.
  - Edges are recorded regardless of mask and state.
- Mask: MaskWr updates mask on the next edge. A masked pending bit stays pending and becomes eligible once unmasked.
- Eligible set: elig = pending & mask. Winner = lowest index set in elig.
- States: IDLE, REQ, SERVICE.
  - IDLE: if elig != 0, latch winner into IntId and go to REQ. IntReq=1 from the next cycle. The earliest IntReq is 2 clocks after the irq rising edge.
  - REQ: IntReq=1. IntId and Vector are frozen while in REQ, even if a higher-priority source becomes pending.
    - IntAck=1: clear pending[IntId], go to SERVICE. IntReq=0 and InService=1 on the following cycle.
    - Else, if mask[IntId] cleared or pending[IntId] no longer set: withdraw to IDLE with IntReq=0. Re-arbitration occurs on the next IDLE cycle.
    - IntAck takes priority over withdrawal in the same cycle.
  - SERVICE: InService=1, IntReq=0, IntId held.
    - EOI=1: go to IDLE, InService=0. The next eligible source may be requested on the cycle after returning to IDLE.
    - New edges keep accumulating in pending.
- Ignored inputs: IntAck outside REQ; EOI outside SERVICE.
- Simultaneous set/clear: if edge[IntId] coincides with the ack clear of the same bit, set wins and the bit remains pending (re-request after EOI).
- Vector arithmetic: 32-bit, wrap modulo 2^32, no overflow flag.
- All outputs are registered. Vector is combinational from registered IntId only.

Optional Feature:
IRQ_SYNC_EN
- Defined: each irq bit passes through a 2-flop synchronizer (reset to 0) before edge detection. This adds 2 cycles, so the earliest IntReq is 4 clocks after the edge.
- Undefined: irq is used directly, and the source must be synchronous to Clock.
- All other behaviour is identical.

Test Plan (defaults, IRQ_SYNC_EN undefined):
- Basic service: Reset, then MaskWr with MaskData=2'b11; pulse irq[1] -> IntReq=1 two clocks later, IntId=1, Vector=32'h108. IntAck -> next cycle IntReq=0, InService=1, Pending=2'b00. EOI -> InService=0.
- Priority and freeze: irq[1] edge, then irq[0] edge while in REQ -> IntId stays 1 until ack. After EOI -> IntReq with IntId=0, Vector=32'h100.
- Masked source: mask=2'b01; irq[1] edge -> Pending=2'b10, IntReq stays 0. MaskWr 2'b11 -> IntReq=1, IntId=1.
- Withdraw: in REQ for IntId=0, write mask=2'b00 -> IntReq=0 next cycle, Pending=2'b01 retained.
- Set/clear collision and stray handshakes: irq[0] re-edge in the IntAck cycle -> Pending[0]=1 after ack, re-request after EOI. Stray IntAck in IDLE and stray EOI in REQ -> no state change.
- Reset in SERVICE with Pending=2'b10 -> all outputs at reset values, Pending=0, mask=0.
